// File: rtl/mod_mul_red_pipe.sv
// mod_mul_red_pipe: LANES-wide pipelined GF(MOD) multiply/reduce unit.
// Per lane: x = mode ? a : a_lo*b, result = x mod MOD via Barrett reduction.
// Pipeline: input capture -> x -> Barrett remainder -> corrected result.
// Optional macro MOD_MUL_RED_ACC_EN adds i_acc_clr and per-lane accumulators.
module mod_mul_red_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MOD   = 251,
  parameter int unsigned LANES = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_mode,
  input  logic [LANES*2*WIDTH-1:0]   i_a,
  input  logic [LANES*WIDTH-1:0]     i_b,
  output logic [LANES*WIDTH-1:0]     o_c,
  output logic                       o_done,
  output logic                       o_err
`ifdef MOD_MUL_RED_ACC_EN
  ,
  input  logic                       i_acc_clr
`endif
);

  localparam int unsigned XW = 2 * WIDTH;   // full operand / product width
  localparam int unsigned MW = WIDTH + 1;   // mu and quotient width
  localparam int unsigned RW = WIDTH + 2;   // Barrett remainder width (< 3*MOD)

  localparam logic [XW:0]       POW2  = {1'b1, {XW{1'b0}}};
  localparam logic [XW:0]       MOD_X = (XW+1)'(MOD);
  localparam logic [XW:0]       MU_X  = POW2 / MOD_X;
  localparam logic [MW-1:0]     MU    = MU_X[MW-1:0];
  localparam logic [WIDTH-1:0]  MOD_W = WIDTH'(MOD);
  localparam logic [RW-1:0]     MOD_R = RW'(MOD);

  // input capture stage
  logic                     v0;
  logic                     mode0;
  logic [LANES*2*WIDTH-1:0] a0;
  logic [LANES*WIDTH-1:0]   b0;

  // stage 1: operand x and range flag
  logic             v1;
  logic             err1;
  logic [XW-1:0]    x1   [LANES];
  logic [XW-1:0]    x_c  [LANES];
  logic             err_c;

  // stage 2: Barrett remainder
  logic             v2;
  logic             err2;
  logic [RW-1:0]    r2   [LANES];
  logic [MW-1:0]    q_c  [LANES];
  logic [RW-1:0]    r_c  [LANES];

  // stage 3: final correction
  logic [RW-1:0]    s1_c  [LANES];
  logic [RW-1:0]    s2_c  [LANES];
  logic [WIDTH-1:0] red_c [LANES];
  logic [WIDTH-1:0] res_c [LANES];

`ifdef MOD_MUL_RED_ACC_EN
  logic             clr0;
  logic             clr1;
  logic             clr2;
  logic [WIDTH-1:0] acc   [LANES];
  logic [WIDTH:0]   sum_c [LANES];
`endif

  // Capture operands; only the valid bit needs reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) v0 <= 1'b0;
    else       v0 <= i_start;
    mode0 <= i_mode;
    a0    <= i_a;
    b0    <= i_b;
`ifdef MOD_MUL_RED_ACC_EN
    clr0  <= i_acc_clr;
`endif
  end

  // Select reduce operand or form the product; flag out-of-range residues.
  always_comb begin
    err_c = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      x_c[k] = mode0 ? a0[k*XW +: XW]
                     : {{WIDTH{1'b0}}, a0[k*XW +: WIDTH]} * {{WIDTH{1'b0}}, b0[k*WIDTH +: WIDTH]};
      if (!mode0 && ((a0[k*XW +: WIDTH] >= MOD_W) || (b0[k*WIDTH +: WIDTH] >= MOD_W)))
        err_c = 1'b1;
    end
  end

  // Stage 1 register.
  always_ff @(posedge i_clk) begin
    if (i_rst) v1 <= 1'b0;
    else       v1 <= v0;
    err1 <= err_c;
    for (int unsigned k = 0; k < LANES; k++) x1[k] <= x_c[k];
`ifdef MOD_MUL_RED_ACC_EN
    clr1 <= clr0;
`endif
  end

  // Barrett estimate; the remainder is formed modulo 2^RW since it is known to be < 3*MOD.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      q_c[k] = MW'(({{MW{1'b0}}, x1[k]} * {{XW{1'b0}}, MU}) >> XW);
      r_c[k] = RW'(x1[k]) - (RW'(q_c[k]) * MOD_R);
    end
  end

  // Stage 2 register.
  always_ff @(posedge i_clk) begin
    if (i_rst) v2 <= 1'b0;
    else       v2 <= v1;
    err2 <= err1;
    for (int unsigned k = 0; k < LANES; k++) r2[k] <= r_c[k];
`ifdef MOD_MUL_RED_ACC_EN
    clr2 <= clr1;
`endif
  end

  // Two conditional subtractions bring the remainder into 0..MOD-1.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      s1_c[k]  = (r2[k]   >= MOD_R) ? r2[k]   - MOD_R : r2[k];
      s2_c[k]  = (s1_c[k] >= MOD_R) ? s1_c[k] - MOD_R : s1_c[k];
      red_c[k] = WIDTH'(s2_c[k]);
    end
  end

`ifdef MOD_MUL_RED_ACC_EN
  // Modular accumulate of the reduced value, or restart from it on clear.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      sum_c[k] = {1'b0, acc[k]} + {1'b0, red_c[k]};
      if (clr2)
        res_c[k] = red_c[k];
      else if (sum_c[k] >= {1'b0, MOD_W})
        res_c[k] = WIDTH'(sum_c[k] - {1'b0, MOD_W});
      else
        res_c[k] = WIDTH'(sum_c[k]);
    end
  end

  // Accumulators advance only on completing operations.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < LANES; k++) acc[k] <= '0;
    end else if (v2) begin
      for (int unsigned k = 0; k < LANES; k++) acc[k] <= res_c[k];
    end
  end
`else
  // Without accumulation the result is the reduced value.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) res_c[k] = red_c[k];
  end
`endif

  // Output register: results and flag hold between completions.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      o_c    <= '0;
    end else begin
      o_done <= v2;
      if (v2) begin
        o_err <= err2;
        for (int unsigned k = 0; k < LANES; k++) o_c[k*WIDTH +: WIDTH] <= res_c[k];
      end
    end
  end

endmodule
